// File: rtl/comparator_arbiter.sv
// comparator_arbiter: one 32-bit compare datapath shared by NUM_REQ requesters
// through round-robin arbitration, with a single-entry registered response
// buffer that honours downstream backpressure.
// Optional feature macro: COMPARATOR_ARBITER_SIGNED_EN adds signed compare
// codes 101 (signed <) and 110 (signed >=); otherwise 101..111 flag rsp_err.
module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op1,
  input  logic [32*NUM_REQ-1:0]  req_op2,
  input  logic [3*NUM_REQ-1:0]   req_operation,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_res,
  output logic                   rsp_err
);

  localparam int unsigned NREQ = NUM_REQ;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;

  logic              found;
  logic [ID_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [31:0]       sel_op1;
  logic [31:0]       sel_op2;
  logic [2:0]        sel_code;
  logic              can_accept;
  logic              transfer;
  logic              cmp_res;
  logic              cmp_err;
  logic [ID_W-1:0]   rr_next;

  // Round-robin scan from rr_ptr; selects the first valid requester and its operands
  always_comb begin
    int unsigned idx;
    idx        = 0;
    found      = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    sel_op1    = '0;
    sel_op2    = '0;
    sel_code   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found           = 1'b1;
        win_idx         = ID_W'(idx);
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
        sel_op1         = req_op1[idx*32 +: 32];
        sel_op2         = req_op2[idx*32 +: 32];
        sel_code        = req_operation[idx*3 +: 3];
      end
    end
  end

  // Grant only when the buffer can take a result this cycle, and never in reset
  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    transfer   = rst_n && found && can_accept;
    req_ready  = transfer ? win_onehot : '0;
    rr_next    = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Compare the winner's operands; unsupported codes give err=1, res=0
  always_comb begin
    cmp_res = 1'b0;
    cmp_err = 1'b0;
    case (sel_code)
      3'b000: cmp_res = (sel_op1 == sel_op2);
      3'b001: cmp_res = (sel_op1 >= sel_op2);
      3'b010: cmp_res = (sel_op1 >  sel_op2);
      3'b011: cmp_res = (sel_op1 <= sel_op2);
      3'b100: cmp_res = (sel_op1 <  sel_op2);
`ifdef COMPARATOR_ARBITER_SIGNED_EN
      3'b101: cmp_res = ($signed(sel_op1) <  $signed(sel_op2));
      3'b110: cmp_res = ($signed(sel_op1) >= $signed(sel_op2));
`endif
      default: cmp_err = 1'b1;
    endcase
  end

  // Response buffer state, registered response fields and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rsp_id  <= '0;
      rsp_res <= 1'b0;
      rsp_err <= 1'b0;
      rr_ptr  <= '0;
    end else if (transfer) begin
      state   <= FULL;
      rsp_id  <= win_idx;
      rsp_res <= cmp_res;
      rsp_err <= cmp_err;
      rr_ptr  <= rr_next;
    end else if (state == FULL && rsp_ready) begin
      state   <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_comparator_arbiter.sv
// tb_comparator_arbiter: directed vectors with hand-computed expectations for
// comparator_arbiter (NUM_REQ=4, ID_W=2).
module tb_comparator_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [3*NUM_REQ-1:0]  req_operation;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_res;
  logic                  rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  comparator_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_operation (req_operation),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_res       (rsp_res),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_op1[i*32 +: 32]     = a;
    req_op2[i*32 +: 32]     = b;
    req_operation[i*3 +: 3] = op;
    req_valid[i]            = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic [ID_W-1:0] id, input logic res, input logic err);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_res"},   32'(rsp_res),   32'(res));
    check({tag, "_err"},   32'(rsp_err),   32'(err));
  endtask

  logic [NUM_REQ-1:0] rr_res_exp;

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_op1       = '0;
    req_op2       = '0;
    req_operation = '0;
    rsp_ready     = 1'b0;

    // Reset with every requester valid
    req_valid = '1;
    step();
    step();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_res",   32'(rsp_res),   32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2: 0x10 == 0x10
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    drive(2, 32'h10, 32'h10, 3'b000);
    #1 check("single_ready", 32'(req_ready), 32'b0100);
    step();
    check_rsp("single", 2'd2, 1'b1, 1'b0);
    req_valid = '0;
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);

    // Fill the buffer (requester 3, 5 >= 7 false), then reset while FULL
    rsp_ready = 1'b0;
    drive(3, 32'd5, 32'd7, 3'b001);
    #1 check("r3_ready", 32'(req_ready), 32'b1000);
    step();
    check_rsp("r3", 2'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(0, 32'd3, 32'd9, 3'b100);   // 3 < 9   -> 1
    drive(1, 32'd9, 32'd3, 3'b010);   // 9 > 3   -> 1
    drive(2, 32'd9, 32'd9, 3'b011);   // 9 <= 9  -> 1
    drive(3, 32'd2, 32'd9, 3'b001);   // 2 >= 9  -> 0
    rr_res_exp = 4'b0111;
    #1 check("rst_full_ready", 32'(req_ready), 32'd0);
    step();
    step();
    check("rst_full_valid", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;

    // Round robin with all requesters valid: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      step();
      check_rsp($sformatf("rr%0d", k), 2'(k % 4), rr_res_exp[k % 4], 1'b0);
    end

    // Backpressure: hold response from requester 0, no grants
    rsp_ready = 1'b0;
    #1 check("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_rsp($sformatf("bp%0d", k), 2'd0, 1'b1, 1'b0);
      check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    check_rsp("bp_release", 2'd1, 1'b1, 1'b0);

    // Unsigned: 0xFFFFFFFF < 1 is false
    req_valid = '0;
    drive(2, 32'hFFFF_FFFF, 32'h1, 3'b100);
    #1 check("uns_ready", 32'(req_ready), 32'b0100);
    step();
    check_rsp("uns", 2'd2, 1'b0, 1'b0);

    // Code 111 errors but still rotates the pointer past requester 3
    req_valid = '0;
    drive(3, 32'd5, 32'd5, 3'b111);
    drive(0, 32'd0, 32'd0, 3'b000);
    #1 check("err_ready", 32'(req_ready), 32'b1000);
    step();
    check_rsp("err", 2'd3, 1'b0, 1'b1);
    check("err_rot_ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("err_rot", 2'd0, 1'b1, 1'b0);

    // Signed codes: -1 < 1 and -1 >= 1
    req_valid = '0;
    drive(1, 32'hFFFF_FFFF, 32'h1, 3'b101);
    #1 check("s101_ready", 32'(req_ready), 32'b0010);
    step();
`ifdef COMPARATOR_ARBITER_SIGNED_EN
    check_rsp("s101", 2'd1, 1'b1, 1'b0);
`else
    check_rsp("s101", 2'd1, 1'b0, 1'b1);
`endif
    req_valid = '0;
    drive(2, 32'hFFFF_FFFF, 32'h1, 3'b110);
    #1 check("s110_ready", 32'(req_ready), 32'b0100);
    step();
`ifdef COMPARATOR_ARBITER_SIGNED_EN
    check_rsp("s110", 2'd2, 1'b0, 1'b0);
`else
    check_rsp("s110", 2'd2, 1'b0, 1'b1);
`endif

    // Idle with rsp_ready high drains the buffer
    req_valid = '0;
    step();
    check("final_valid", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
